// File: rtl/fpdiv_seq.sv
// Control sequencer for the Goldschmidt divide datapath: walks the multiplier
// operand selects and register load enables through init, ITERS refinements and remainder.
module fpdiv_seq #(
  parameter int ITERS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       dz,
  input  logic       abort,
  output logic [1:0] sel_muxa,
  output logic [1:0] sel_muxb,
  output logic       enA,
  output logic       enB,
  output logic       enC,
  output logic       enR,
  output logic       busy,
  output logic       done,
  output logic       dz_flag
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_D = 3'd1,
    INIT_X = 3'd2,
    ITER_Q = 3'd3,
    ITER_D = 3'd4,
    REM    = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(ITERS - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       dz_q, dz_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      dz_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dz_q  <= dz_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dz_nxt    = dz_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (dz) begin
            state_nxt = DONE;
            dz_nxt    = 1'b1;
          end else begin
            state_nxt = INIT_D;
          end
        end
      end
      INIT_D: state_nxt = INIT_X;
      INIT_X: begin
        cnt_nxt   = 3'd0;
        state_nxt = ITER_Q;
      end
      ITER_Q: state_nxt = ITER_D;
      ITER_D: begin
        cnt_nxt   = cnt + 3'd1;
        state_nxt = (cnt == CNT_LAST) ? REM : ITER_Q;
      end
      REM: state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        dz_nxt    = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
    // Cancel wins over every transition once a divide is in flight.
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      dz_nxt    = 1'b0;
    end
  end

  always_comb begin
    sel_muxa = 2'b00;
    sel_muxb = 2'b00;
    enA      = 1'b0;
    enB      = 1'b0;
    enC      = 1'b0;
    enR      = 1'b0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    dz_flag  = dz_q;
    case (state)
      INIT_D: begin
        sel_muxa = 2'b10;
        sel_muxb = 2'b00;
        enA      = 1'b1;
        enC      = 1'b1;
      end
      INIT_X: begin
        sel_muxa = 2'b10;
        sel_muxb = 2'b01;
        enB      = 1'b1;
      end
      ITER_Q: begin
        sel_muxa = 2'b00;
        sel_muxb = 2'b10;
        enB      = 1'b1;
      end
      ITER_D: begin
        sel_muxa = 2'b00;
        sel_muxb = 2'b11;
        enA      = 1'b1;
        enC      = 1'b1;
      end
      REM: begin
        sel_muxa = 2'b01;
        sel_muxb = 2'b10;
        enR      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpdiv_seq.sv
// Checks three builds (ITERS = 1, 3, 7) side by side against a schedule-queue
// model: each accepted divide enqueues the per-cycle output words it must produce.
module tb_fpdiv_seq;

  typedef logic [10:0] word_t;
  typedef word_t wq_t[$];

  // {sel_muxa, sel_muxb, enA, enB, enC, enR, busy, done, dz_flag}
  localparam word_t W_IDLE  = 11'b00_00_0000_000;
  localparam word_t W_INITD = 11'b10_00_1010_100;
  localparam word_t W_INITX = 11'b10_01_0100_100;
  localparam word_t W_ITERQ = 11'b00_10_0100_100;
  localparam word_t W_ITERD = 11'b00_11_1010_100;
  localparam word_t W_REM   = 11'b01_10_0001_100;
  localparam word_t W_DONE  = 11'b00_00_0000_110;
  localparam word_t W_DZ    = 11'b00_00_0000_111;

  logic clk, rst, start, dz, abort;
  logic [1:0] sa1, sb1, sa3, sb3, sa7, sb7;
  logic a1, b1, c1, r1, bs1, dn1, f1;
  logic a3, b3, c3, r3, bs3, dn3, f3;
  logic a7, b7, c7, r7, bs7, dn7, f7;
  word_t o1, o3, o7;
  wq_t q1, q3, q7;
  int n_tests, n_fail;

  assign o1 = {sa1, sb1, a1, b1, c1, r1, bs1, dn1, f1};
  assign o3 = {sa3, sb3, a3, b3, c3, r3, bs3, dn3, f3};
  assign o7 = {sa7, sb7, a7, b7, c7, r7, bs7, dn7, f7};

  fpdiv_seq #(.ITERS(1)) u_it1 (
    .clock(clk), .reset(rst), .start(start), .dz(dz), .abort(abort),
    .sel_muxa(sa1), .sel_muxb(sb1), .enA(a1), .enB(b1), .enC(c1), .enR(r1),
    .busy(bs1), .done(dn1), .dz_flag(f1));

  fpdiv_seq #(.ITERS(3)) u_it3 (
    .clock(clk), .reset(rst), .start(start), .dz(dz), .abort(abort),
    .sel_muxa(sa3), .sel_muxb(sb3), .enA(a3), .enB(b3), .enC(c3), .enR(r3),
    .busy(bs3), .done(dn3), .dz_flag(f3));

  fpdiv_seq #(.ITERS(7)) u_it7 (
    .clock(clk), .reset(rst), .start(start), .dz(dz), .abort(abort),
    .sel_muxa(sa7), .sel_muxb(sb7), .enA(a7), .enB(b7), .enC(c7), .enR(r7),
    .busy(bs7), .done(dn7), .dz_flag(f7));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic wq_t sched(int iters, logic dzv);
    wq_t q;
    q.delete();
    if (dzv) begin
      q.push_back(W_DZ);
    end else begin
      q.push_back(W_INITD);
      q.push_back(W_INITX);
      for (int i = 0; i < iters; i++) begin
        q.push_back(W_ITERQ);
        q.push_back(W_ITERD);
      end
      q.push_back(W_REM);
      q.push_back(W_DONE);
    end
    return q;
  endfunction

  // One clock edge of the model: busy divides consume a step (abort drops the rest),
  // an idle unit accepts start.
  function automatic wq_t advance(wq_t q, int iters, logic s, logic d, logic a);
    wq_t r;
    r = q;
    if (r.size() == 0) begin
      if (s) r = sched(iters, d);
    end else begin
      void'(r.pop_front());
      if (a) r.delete();
    end
    return r;
  endfunction

  function automatic word_t head(wq_t q);
    return (q.size() == 0) ? W_IDLE : q[0];
  endfunction

  task automatic chk(input string tag, input word_t got, input word_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b expected=%b", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    chk("iters1", o1, head(q1));
    chk("iters3", o3, head(q3));
    chk("iters7", o7, head(q7));
  endtask

  task automatic step(input logic s, input logic d, input logic a);
    check_all();
    start = s;
    dz    = d;
    abort = a;
    q1 = advance(q1, 1, s, d, a);
    q3 = advance(q3, 3, s, d, a);
    q7 = advance(q7, 7, s, d, a);
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    q1.delete(); q3.delete(); q7.delete();
    rst = 1'b1; start = 1'b0; dz = 1'b0; abort = 1'b0;
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // plain divide, then the divisor-zero short cut
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 20; k++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 4; k++) step(1'b0, 1'b0, 1'b0);

    // start pulses while busy, then back-to-back restart
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 23; k++) step((k == 3) || (k == 10) || (k == 11), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0);

    // abort mid-iteration, then a normal divide
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 9; k++) step(1'b0, 1'b0, k == 5);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 20; k++) step(1'b0, 1'b0, 1'b0);

    // asynchronous reset while all three builds sit in ITER_D (cycle 4)
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 4; k++) step(1'b0, 1'b0, 1'b0);
    check_all();
    #2 rst = 1'b1;
    #1;
    q1.delete(); q3.delete(); q7.delete();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 20; k++) step(1'b0, 1'b0, 1'b0);

    // abort together with start in IDLE, and abort landing on DONE
    step(1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 10; k++) step(1'b0, 1'b0, k == 9);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0);

    // random traffic
    for (int k = 0; k < 800; k++)
      step($urandom_range(0, 9) < 4, $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0);
    for (int k = 0; k < 22; k++) step(1'b0, 1'b0, 1'b0);
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpdiv_seq.md
# fpdiv_seq

Sequencer for the Goldschmidt floating-point divide datapath (`fpdiv`). Accepts a start request, drives the multiplier operand selects (`sel_muxa`, `sel_muxb`) and the register load enables (`enA`, `enB`, `enC`, `enR`) through initial-approximation, iteration and remainder steps, then reports completion with a one-cycle `done` pulse. Sits between the FPU issue logic and the divide datapath; one divide in flight at a time.

## Interface
- ITERS, 3, number of Goldschmidt refinement iterations; legal range 1..7.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a divide; accepted only in IDLE.
- dz  in  1  divisor-is-zero flag, sampled with an accepted `start`.
- abort  in  1  synchronous cancel; honoured in any non-IDLE state.
- sel_muxa  out  2  A-operand select: 00 regA, 01 d, 10 initial approximation.
- sel_muxb  out  2  B-operand select: 00 d, 01 x, 10 regB, 11 regC.
- enA, enB, enC, enR  out  1 each  load enables for regA/regB/regC/regR.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- dz_flag  out  1  high with `done` when the divide was short-circuited by `dz`.

## Operation
- States: IDLE, INIT_D, INIT_X, ITER_Q, ITER_D, REM, DONE. 3-bit iteration counter `cnt`.
- Outputs are Moore-decoded from the state register; no output depends combinationally on inputs.
- IDLE: sels 00, all enables 0. `start`=1 & `dz`=0 -> INIT_D; `start`=1 & `dz`=1 -> DONE with `dz_flag` latched 1. Otherwise stay.
- INIT_D: sel_muxa=10, sel_muxb=00, enA=1, enC=1 (regA <- ~(ia*d), regC <- ia*d). -> INIT_X.
- INIT_X: sel_muxa=10, sel_muxb=01, enB=1 (regB <- ia*x). cnt <- 0. -> ITER_Q.
- ITER_Q: sel_muxa=00, sel_muxb=10, enB=1 (regB <- regA*regB). -> ITER_D.
- ITER_D: sel_muxa=00, sel_muxb=11, enA=1, enC=1 (regC <- regA*regC, regA <- complement). cnt <- cnt+1. If cnt==ITERS-1 -> REM, else -> ITER_Q.
- REM: sel_muxa=01, sel_muxb=10, enR=1 (regR <- d*q for rounding remainder). -> DONE.
- DONE: all enables 0, sels 00, done=1. -> IDLE. `dz_flag` cleared on leaving DONE.
- Exactly one enable pattern per state; enables never asserted in IDLE or DONE.
- `start` while busy is ignored (not queued).
- `abort`=1 in any non-IDLE state: next state IDLE, no `done`, `dz_flag` cleared; abort in DONE still lets `done` pulse in that cycle but returns to IDLE.
- `abort` and `start` in IDLE same cycle: abort ignored, start accepted.
- cnt width 3; compare against ITERS-1, never wraps for legal ITERS.

## Timing
- Reset (async): state IDLE, cnt 0, busy 0, done 0, dz_flag 0, all enables 0, sels 00, effective immediately without clock.
- `start` sampled high at edge 0: INIT_D in cycle 1, INIT_X cycle 2, ITER_Q/ITER_D pairs cycles 3..2+2*ITERS, REM cycle 3+2*ITERS, DONE cycle 4+2*ITERS, IDLE cycle 5+2*ITERS.
- ITERS=3: done high in cycle 10 only; busy high cycles 1..10.
- dz path: done and dz_flag high in cycle 1, IDLE in cycle 2.
- Back-to-back: `start` held high in DONE is ignored; earliest next accept is the first IDLE cycle, giving INIT_D at cycle 6+2*ITERS.
- Reset mid-operation: outputs drop to reset values asynchronously; first start after release behaves as from power-up.

## Test plan
- Reset then start (ITERS=3, dz=0): enable/select sequence per state matches Operation; regR loaded in cycle 9, done=1 in cycle 10 only, busy low in cycle 11.
- start with dz=1: done=1 and dz_flag=1 in cycle 1, no enable ever high, IDLE in cycle 2.
- start pulsed again in cycles 3 and 10 during a divide: ignored; single done in cycle 10; new start in cycle 11 gives done in cycle 21.
- abort asserted in cycle 5 (ITER_Q/ITER_D): IDLE in cycle 6, all enables 0, no done pulse, next start completes normally.
- Async reset asserted mid-cycle during ITER_D: enA/enC fall without a clock edge, busy=0; after release, start yields done exactly 10 cycles later.
- ITERS=1 and ITERS=7 builds: done in cycles 6 and 18 respectively; number of enB pulses = ITERS+1, enR pulses = 1.
